// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants shared by the key schedule: S-box, Rcon, xtime, key sizes.
package aes_pkg;

  localparam int AES128_NK = 4;
  localparam int AES128_NR = 10;
  localparam int AES192_NK = 6;
  localparam int AES192_NR = 12;
  localparam int AES256_NK = 8;
  localparam int AES256_NR = 14;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entry 0 is never used by the recurrence; the list runs to 14 to cover AES-256 with margin.
  localparam logic [7:0] RCON_LIST [0:14] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    if (j <= 14) begin
      r = RCON_LIST[j[3:0]];
    end else begin
      r = RCON_LIST[14];
      for (int k = 15; k <= j; k++) r = xtime(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box byte substitution.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  assign subst = SBOX[value];

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128/192/256 key schedule with a registered round-key bus.
// Optional macro KEYEXP_VALID_EN adds in_valid/out_valid load qualification.
module key_expansion
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nb = 4,
  parameter int Nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*Nk-1:0]       key,
`ifdef KEYEXP_VALID_EN
  input  logic                   in_valid,
  output logic                   out_valid,
`endif
  output logic [32*Nk*Nr-1:0]    fullKeys
);

  localparam int NW = Nk * (Nr + 1);
  localparam int KB = 32 * Nk * Nr;
  // Unsupported parameter sets load zeros rather than a meaningless schedule.
  localparam bit CFG_OK = (Nb == 4) &&
                          ((Nk == AES128_NK && Nr == AES128_NR) ||
                           (Nk == AES192_NK && Nr == AES192_NR) ||
                           (Nk == AES256_NK && Nr == AES256_NR));

  logic [31:0]   words [0:NW-1];
  logic [KB-1:0] next_keys;

  for (genvar i = 0; i < NW; i++) begin : g_w
    logic [31:0] w;
    if (i < Nk) begin : g_key
      assign w = key[32*(Nk-i)-1 -: 32];
    end else begin : g_rec
      localparam int K = i - Nk;
      logic [31:0] prev;
      logic [31:0] temp;
      assign prev = g_w[i-1].w;

      if (i % Nk == 0) begin : g_rot
        localparam logic [7:0] RC = rcon(i / Nk);
        logic [31:0] rot;
        logic [31:0] sub;
        assign rot = {prev[23:0], prev[31:24]};
        for (genvar b = 0; b < 4; b++) begin : g_sb
          aes_sbox u_sbox (.value(rot[8*b+7 -: 8]), .subst(sub[8*b+7 -: 8]));
        end
        assign temp = sub ^ {RC, 24'h0};
      end else if (Nk > 6 && i % Nk == 4) begin : g_sub
        logic [31:0] sub;
        for (genvar b = 0; b < 4; b++) begin : g_sb
          aes_sbox u_sbox (.value(prev[8*b+7 -: 8]), .subst(sub[8*b+7 -: 8]));
        end
        assign temp = sub;
      end else begin : g_pass
        assign temp = prev;
      end

      assign w = g_w[i-Nk].w ^ temp;
      // Chunk K/Nk, first word of each chunk in its most significant slot.
      assign next_keys[32*Nk*(K/Nk) + 32*(Nk - K%Nk) - 1 -: 32] = w;
    end
    assign words[i] = w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fullKeys <= '0;
`ifdef KEYEXP_VALID_EN
    end else if (in_valid) begin
`else
    end else begin
`endif
      fullKeys <= CFG_OK ? next_keys : '0;
    end
  end

`ifdef KEYEXP_VALID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= in_valid;
  end
`endif

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - directed FIPS-197 vectors for key_expansion at all three key sizes.
module tb_key_expansion;

  logic          clk;
  logic          reset;
  logic [127:0]  key128;
  logic [191:0]  key192;
  logic [255:0]  key256;
  logic [1279:0] fk128;
  logic [2303:0] fk192;
  logic [3583:0] fk256;
`ifdef KEYEXP_VALID_EN
  logic          in_valid;
  logic          ov128, ov192, ov256;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  key_expansion #(.Nk(4), .Nb(4), .Nr(10)) u_dut128 (
    .clk(clk), .reset(reset), .key(key128),
`ifdef KEYEXP_VALID_EN
    .in_valid(in_valid), .out_valid(ov128),
`endif
    .fullKeys(fk128)
  );

  key_expansion #(.Nk(6), .Nb(4), .Nr(12)) u_dut192 (
    .clk(clk), .reset(reset), .key(key192),
`ifdef KEYEXP_VALID_EN
    .in_valid(in_valid), .out_valid(ov192),
`endif
    .fullKeys(fk192)
  );

  key_expansion #(.Nk(8), .Nb(4), .Nr(14)) u_dut256 (
    .clk(clk), .reset(reset), .key(key256),
`ifdef KEYEXP_VALID_EN
    .in_valid(in_valid), .out_valid(ov256),
`endif
    .fullKeys(fk256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    reset  = 1'b1;
    key128 = K128;
    key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
`ifdef KEYEXP_VALID_EN
    in_valid = 1'b1;
`endif

    #2;
    check("rst_fk128_lo", 256'(fk128[127:0]), 256'h0);
    check("rst_fk128_hi", 256'(fk128[1279:1152]), 256'h0);
    check("rst_fk192_lo", 256'(fk192[191:0]), 256'h0);
    check("rst_fk256_lo", 256'(fk256[255:0]), 256'h0);
`ifdef KEYEXP_VALID_EN
    check("rst_out_valid", 256'(ov128), 256'h0);
`endif

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("aes128_w4_7", 256'({u_dut128.words[4], u_dut128.words[5], u_dut128.words[6], u_dut128.words[7]}),
          256'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_w8_11", 256'({u_dut128.words[8], u_dut128.words[9], u_dut128.words[10], u_dut128.words[11]}),
          256'hf2c295f27a96b9435935807a7359f67f);
    check("aes128_fk_lo", 256'(fk128[127:0]), 256'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_fk_hi", 256'(fk128[1279:1152]), 256'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("aes192_fk_lo", 256'(fk192[191:0]),
          256'hfe0c91f72402f5a5ec12068e6c827f6b0e7a95b95c56fec2);
    check("aes256_w8_13", 256'({u_dut256.words[8], u_dut256.words[9], u_dut256.words[10],
                                u_dut256.words[11], u_dut256.words[12], u_dut256.words[13]}),
          256'h9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cd);
    check("aes256_w12_sub", 256'(u_dut256.words[12]), 256'ha8b09c1a);
    check("aes256_fk_lo", 256'(fk256[255:64]),
          256'h9ba354118e6925afa51a8b5f2067fcdea8b09c1a93d194cd);

    // Asynchronous reset between edges, then release and reload on one edge.
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async_rst_fk128", 256'(fk128[127:0]), 256'h0);
    check("async_rst_fk256", 256'(fk256[255:0]), 256'h0);
    #2;
    reset = 1'b0;
    #1;
    check("post_rst_no_edge", 256'(fk128[127:0]), 256'h0);
    @(posedge clk); #1;
    check("reload_fk128_lo", 256'(fk128[127:0]), 256'ha0fafe1788542cb123a339392a6c7605);
    check("reload_fk128_hi", 256'(fk128[1279:1152]), 256'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Key switch to all-zero between edges.
    key128 = 128'h0;
    #1;
    check("switch_hold", 256'(fk128[127:0]), 256'ha0fafe1788542cb123a339392a6c7605);
    check("switch_w4_comb", 256'(u_dut128.words[4]), 256'h62636363);
    @(posedge clk); #1;
    check("switch_fk_lo", 256'(fk128[127:0]), 256'h62636363626363636263636362636363);
    check("switch_fk_hi", 256'(fk128[1279:1152]), 256'hb4ef5bcb3e92e21123e951cf6f8f188e);

`ifdef KEYEXP_VALID_EN
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("valid_drop", 256'(ov128), 256'h0);
    key128 = K128;
    @(posedge clk); #1;
    check("valid_hold_fk", 256'(fk128[127:0]), 256'h62636363626363636263636362636363);
    check("valid_hold_ov", 256'(ov128), 256'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("valid_load_fk", 256'(fk128[127:0]), 256'ha0fafe1788542cb123a339392a6c7605);
    check("valid_load_ov", 256'(ov128), 256'h1);
    @(posedge clk); #1;
    check("valid_after_ov", 256'(ov128), 256'h0);
    check("valid_after_fk", 256'(fk128[1279:1152]), 256'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
- Parameterised AES key-schedule generator for AES-128, AES-192 and AES-256.
- Expands the cipher key into the following Nk·Nr round-key words w[Nk] … w[Nk·(Nr+1)−1] using the FIPS-197 recurrence.
- Presents the words as one wide registered bus.
- Sits beside the encrypt datapath, which slices round keys from this bus.

Parameters:
- Nk, 4, key length in 32-bit words (4, 6 or 8).
- Nb, 4, state columns; fixed at 4, kept for consistency with the cipher.
- Nr, 10, number of rounds (10, 12 or 14, paired with Nk 4, 6, 8).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- key  input  32·Nk  cipher key; w[0] = key[32·Nk−1 : 32·Nk−32], big-endian bytes
- fullKeys  output  32·Nk·Nr  expanded words w[Nk] … w[Nk·(Nr+1)−1]

Behaviour:
- Recurrence for i ≥ Nk:
  - temp = w[i−1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
  - Else if Nk > 6 and i mod Nk = 4: temp = SubWord(temp).
  - w[i] = w[i−Nk] ^ temp.
- RotWord: {b1,b2,b3,b0}. SubWord applies the AES S-box to each byte.
- Rcon[1] = 8'h01; Rcon[j+1] = xtime(Rcon[j]), with xtime reducing by 8'h1b on MSB overflow. This sequence continues past index 10 (…36, 6c, d8, ab, 4d…) for the extra words AES-192 and AES-256 produce.
- Output packing: chunk c (0 … Nr−1) occupies bits [32·Nk·(c+1)−1 : 32·Nk·c] and equals {w[Nk(c+1)], …, w[Nk(c+1)+Nk−1]}, first word most significant.
- Words beyond those the cipher consumes (AES-192/256) are still computed by the same recurrence and output.
- Expansion is fully combinational from key. fullKeys is a register loaded on every rising clk edge, giving a latency of 1 cycle from a stable key.
- A key change mid-stream takes effect at the next edge; there is no partial or mixed-key output.
- reset asserted: fullKeys clears to 0 immediately. It reloads at the first rising edge after deassertion.
- Internal word array `words[0 : Nk·(Nr+1)−1]` holds w[i] and must be visible hierarchically for debug.

Optional Feature:
- Macro KEYEXP_VALID_EN.
- Defined:
  - Adds input `in_valid` and output `out_valid`.
  - fullKeys loads only on edges where in_valid = 1, otherwise holds its value.
  - out_valid is in_valid registered by one cycle and resets to 0.
- Undefined: no extra ports; fullKeys loads every cycle.

Decomposition:
- Shared package `aes_pkg`: the S-box constant table, an xtime function, a default Rcon list, and key-size constants (Nk/Nr pairs 4/10, 6/12, 8/14).
- One sub-module `aes_sbox`: a combinational 8-bit lookup, instantiated 4 per SubWord site via generate.
- The top level holds the generate loop for the recurrence and the output register.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, one edge after reset release:
  - words 4–7 = a0fafe17 88542cb1 23a33939 2a6c7605
  - words 8–11 = f2c295f2 7a96b943 5935807a 7359f67f
  - fullKeys[127:0] = a0fafe1788542cb123a339392a6c7605
  - fullKeys[1279:1152] = d014f9a8c9ee2589e13f0cc8b6630ca6
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: words 6–11 = fe0c91f7 2402f5a5 ec12068e 6c827f6b 0e7a95b9 5c56fec2; fullKeys[191:0] equals their concatenation.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: words 8–13 = 9ba35411 8e6925af a51a8b5f 2067fcde a8b09c1a 93d194cd (exercises the i mod Nk = 4 SubWord rule).
- Reset:
  - Assert reset mid-clock → fullKeys reads 0 with no clock edge.
  - Hold key, deassert → vector 1 values reappear after exactly one rising edge.
- Key switch: change the AES-128 key to all-zero between edges.
  - fullKeys holds the old value until the next edge.
  - Then fullKeys[127:0] = 62636363626363636263636362636363.
- KEYEXP_VALID_EN: change key with in_valid = 0 → fullKeys and out_valid unchanged; pulse in_valid → new keys and out_valid = 1 one cycle later.
